block_memory_ctrl: RTL and testbench
====================================

// Module: block_memory_ctrl
// PURPOSE
//  Clocked main-memory stage directly downstream of the direct-mapped write-back data cache.
//  Serves whole 4-word (128-bit) block transfers: refills on a miss, write-backs on dirty eviction.
//  Models fixed access latency behind a valid/ready request and a one-cycle response pulse.
//  Keeps saturating read/write transfer counters for miss-penalty statistics.
// PARAMETERS
//  LATENCY    4    cycles from request acceptance to resp_valid; legal range >= 1
//  MEM_WORDS  256  32-bit words in the array (1 KiB); equals 2**(ADDR_W-2)
//  ADDR_W     10   byte-address width, identical to the cache address
//  CNT_W      16   width of rd_count / wr_count
// PORTS
//  clk         in   1         rising-edge clock
//  reset       in   1         synchronous, active-high reset
//  req_valid   in   1         cache presents a block request
//  req_ready   out  1         block can accept; high only in IDLE
//  req_write   in   1         1 = write-back block, 0 = refill read
//  req_addr    in   ADDR_W    byte address; [ADDR_W-1:4] selects block, [3:0] ignored
//  req_wdata   in   128       write block; word k at bits [32k+31:32k]
//  resp_valid  out  1         one-cycle completion pulse
//  resp_rdata  out  128       read block (same word order), or echo of written block
//  rd_count    out  CNT_W     completed reads, saturating
//  wr_count    out  CNT_W     completed writes, saturating
// BEHAVIOUR
//  - Array: word w initialised to 32'(w) at time 0; NOT cleared by reset.
//  - Reset (edge with reset=1): state<=IDLE, resp_valid<=0, resp_rdata<=0, counters<=0;
//    any in-flight request dropped, pending write NOT committed. req_ready=1 after reset.
//  - FSM IDLE/BUSY/RESP; req_ready = (state==IDLE), combinational from state.
//  - IDLE: on edge with req_valid=1: latch write, block addr, wdata; cnt<=LATENCY-1; ->BUSY.
//    req_valid=0: stay IDLE.
//  - BUSY: req inputs ignored. If cnt!=0: cnt<=cnt-1. If cnt==0: perform access
//    (read: resp_rdata<=array block; write: array block<=latched wdata,
//    resp_rdata<=latched wdata), resp_valid<=1, bump counter, ->RESP.
//  - RESP: resp_valid high exactly this one cycle; next edge resp_valid<=0, ->IDLE.
//  - Timing: accept at edge E0 -> resp_valid high in cycle after edge E(LATENCY);
//    next accept earliest at edge E(LATENCY+2). req_ready low LATENCY+1 cycles.
//  - resp_rdata holds last value until next completion or reset.
//  - Write committed only at completion edge; a read issued after a write's resp_valid
//    returns the new data.
//  - Counters increment on completion only; hold at 2**CNT_W-1, never wrap.
//  - Reset has priority over every other event in the same cycle.
// TESTING
//  1. reset; read 0x040 -> accept E0, resp_valid only after E4, rdata={32'd19,32'd18,32'd17,32'd16}, rd_count=1.
//  2. write 0x3F0 wdata={D,C,B,A}; then read 0x3FC -> rdata={D,C,B,A}; wr_count=1, rd_count=1.
//  3. req_valid held through BUSY/RESP with addr changing 0x000->0x010 -> only first accepted; 2nd accepted at E6, returns words 4..7.
//  4. reset during 2nd BUSY cycle of write to 0x020 -> no resp_valid; later read 0x020 = {11,10,9,8}; counters restart at 0.
//  5. LATENCY=1 instance, req_valid held high -> accepts at E0,E3,E6; resp_valid in cycles after E1,E4,E7.
//  6. CNT_W=4 instance, 17 reads -> rd_count stays 15, wr_count 0.

Source files
------------

// File: rtl/block_memory_ctrl.sv
// rtl/block_memory_ctrl.sv - fixed-latency 128-bit block memory behind the write-back data cache
module block_memory_ctrl #(
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 10,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [127:0]      req_wdata,
    output logic              resp_valid,
    output logic [127:0]      resp_rdata,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int BLK_W = ADDR_W - 4;
    localparam int CW    = (LATENCY < 2) ? 1 : $clog2(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Power-up image: every word holds its own word index.
    function automatic logic [MEM_WORDS*32-1:0] mem_image();
        logic [MEM_WORDS*32-1:0] img;
        for (int w = 0; w < MEM_WORDS; w++) begin
            img[w*32 +: 32] = 32'(w);
        end
        return img;
    endfunction

    // Array contents survive reset; only the power-up image initialises them.
    logic [MEM_WORDS-1:0][31:0] mem = mem_image();

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             write_q;
    logic [BLK_W-1:0] blk_q;
    logic [127:0]     wdata_q;

    assign req_ready = (state == IDLE);

    // Request/latency/response sequencing; the array is touched only on the completion edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            rd_count   <= '0;
            wr_count   <= '0;
            cnt        <= '0;
            write_q    <= 1'b0;
            blk_q      <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        write_q <= req_write;
                        blk_q   <= req_addr[ADDR_W-1:4];
                        wdata_q <= req_wdata;
                        cnt     <= CW'(LATENCY - 1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (write_q) begin
                            for (int k = 0; k < 4; k++) begin
                                mem[{blk_q, 2'(k)}] <= wdata_q[32*k +: 32];
                            end
                            resp_rdata <= wdata_q;
                            if (wr_count != {CNT_W{1'b1}}) begin
                                wr_count <= wr_count + 1'b1;
                            end
                        end else begin
                            for (int k = 0; k < 4; k++) begin
                                resp_rdata[32*k +: 32] <= mem[{blk_q, 2'(k)}];
                            end
                            if (rd_count != {CNT_W{1'b1}}) begin
                                rd_count <= rd_count + 1'b1;
                            end
                        end
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_memory_ctrl.sv
// tb/tb_block_memory_ctrl.sv - directed plus randomized bench for block_memory_ctrl
module tb_block_memory_ctrl;

    logic         clk = 1'b0;
    logic         reset;

    logic         req_valid, req_ready, req_write, resp_valid;
    logic [9:0]   req_addr;
    logic [127:0] req_wdata, resp_rdata;
    logic [15:0]  rd_count, wr_count;

    logic         req_valid1, req_ready1, resp_valid1;
    logic [9:0]   req_addr1;
    logic [127:0] resp_rdata1;
    logic [15:0]  rd_count1, wr_count1;

    logic         req_valid_c, req_ready_c, resp_valid_c;
    logic [9:0]   req_addr_c;
    logic [127:0] resp_rdata_c;
    logic [3:0]   rd_count_c, wr_count_c;

    int checks = 0;
    int errors = 0;

    logic [31:0] mmem [256];
    int          m_rd, m_wr;

    always #5 clk = ~clk;

    block_memory_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    block_memory_ctrl #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_write(1'b0), .req_addr(req_addr1), .req_wdata(128'd0),
        .resp_valid(resp_valid1), .resp_rdata(resp_rdata1),
        .rd_count(rd_count1), .wr_count(wr_count1)
    );

    block_memory_ctrl #(.CNT_W(4)) dut_c (
        .clk(clk), .reset(reset), .req_valid(req_valid_c), .req_ready(req_ready_c),
        .req_write(1'b0), .req_addr(req_addr_c), .req_wdata(128'd0),
        .resp_valid(resp_valid_c), .resp_rdata(resp_rdata_c),
        .rd_count(rd_count_c), .wr_count(wr_count_c)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] init_blk(input int b);
        return {32'(4*b+3), 32'(4*b+2), 32'(4*b+1), 32'(4*b)};
    endfunction

    function automatic logic [127:0] model_blk(input int b);
        return {mmem[4*b+3], mmem[4*b+2], mmem[4*b+1], mmem[4*b]};
    endfunction

    // One transaction on the default instance; starts and ends at a falling edge with the DUT idle.
    task automatic xfer(input logic w, input logic [9:0] a, input logic [127:0] d);
        int n;
        int b;
        logic [127:0] exp;
        b = int'(a[9:4]);
        check("ready_before_req", 128'(req_ready), 128'(1));
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = 10'($urandom);
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (!resp_valid && n < 20) begin
            check("ready_low_busy", 128'(req_ready), 128'(0));
            @(negedge clk);
            n++;
        end
        check("latency", 128'(n), 128'(4));
        if (w) begin
            for (int k = 0; k < 4; k++) mmem[4*b+k] = d[32*k +: 32];
            exp = d;
            if (m_wr < 65535) m_wr++;
        end else begin
            exp = model_blk(b);
            if (m_rd < 65535) m_rd++;
        end
        check("rdata", resp_rdata, exp);
        check("rd_count", 128'(rd_count), 128'(m_rd));
        check("wr_count", 128'(wr_count), 128'(m_wr));
        @(negedge clk);
        check("resp_pulse_end", 128'(resp_valid), 128'(0));
        check("ready_after_resp", 128'(req_ready), 128'(1));
        check("rdata_hold", resp_rdata, exp);
    endtask

    initial begin
        int n;
        logic [127:0] d;
        logic [127:0] q1 [$];
        logic [9:0] a;

        for (int w = 0; w < 256; w++) mmem[w] = 32'(w);
        m_rd = 0; m_wr = 0;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_valid1 = 1'b0; req_addr1 = '0;
        req_valid_c = 1'b0; req_addr_c = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_resp_valid", 128'(resp_valid), 128'(0));
        check("rst_rdata", resp_rdata, 128'(0));
        check("rst_rd_count", 128'(rd_count), 128'(0));
        check("rst_wr_count", 128'(wr_count), 128'(0));
        check("rst_ready", 128'(req_ready), 128'(1));

        // Refill read of block 4.
        xfer(1'b0, 10'h040, '0);
        check("read_040", resp_rdata, {32'd19, 32'd18, 32'd17, 32'd16});

        // Write-back then read of the same top block through a different byte offset.
        d = {$urandom, $urandom, $urandom, $urandom};
        xfer(1'b1, 10'h3F0, d);
        xfer(1'b0, 10'h3FC, '0);
        check("readback_3f0", resp_rdata, d);

        // req_valid held through BUSY/RESP: only the first is taken, the second at E6.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h000;
        @(negedge clk);
        req_addr = 10'h010;
        n = 0;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        check("held_latency1", 128'(n), 128'(4));
        check("held_rdata1", resp_rdata, model_blk(0));
        @(negedge clk);
        check("held_ready_e5", 128'(req_ready), 128'(1));
        @(negedge clk);
        req_valid = 1'b0;
        check("held_accept_e6", 128'(req_ready), 128'(0));
        n = 0;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        check("held_latency2", 128'(n), 128'(4));
        check("held_rdata2", resp_rdata, model_blk(1));
        if (m_rd < 65535) m_rd++;
        if (m_rd < 65535) m_rd++;
        check("held_rd_count", 128'(rd_count), 128'(m_rd));
        @(negedge clk);

        // Randomized traffic against the model.
        for (int i = 0; i < 20; i++) begin
            xfer(1'($urandom), 10'($urandom), {$urandom, $urandom, $urandom, $urandom});
        end

        // Reset during the second BUSY cycle of a write to 0x020: nothing commits.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h020;
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_rd = 0; m_wr = 0;
        n = 0;
        repeat (6) begin
            if (resp_valid) n++;
            @(negedge clk);
        end
        check("rst_no_resp", 128'(n), 128'(0));
        check("rst2_rdata", resp_rdata, 128'(0));
        check("rst2_rd_count", 128'(rd_count), 128'(0));
        check("rst2_wr_count", 128'(wr_count), 128'(0));
        xfer(1'b0, 10'h020, '0);
        check("dropped_write", resp_rdata, model_blk(2));

        // LATENCY=1 with req_valid held: accepts every third edge.
        a = 10'($urandom);
        req_addr1 = a; req_valid1 = 1'b1; q1.push_back(init_blk(int'(a[9:4])));
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("l1_ready", 128'(req_ready1), 128'(k % 3 == 2));
            check("l1_resp", 128'(resp_valid1), 128'(k % 3 == 1));
            if (resp_valid1 && q1.size() > 0) check("l1_rdata", resp_rdata1, q1.pop_front());
            if (req_ready1) begin
                a = 10'($urandom);
                req_addr1 = a;
                q1.push_back(init_blk(int'(a[9:4])));
            end
        end
        req_valid1 = 1'b0;

        // CNT_W=4: the read counter saturates at 15.
        for (int i = 0; i < 17; i++) begin
            a = 10'($urandom);
            req_valid_c = 1'b1; req_addr_c = a;
            @(negedge clk);
            req_valid_c = 1'b0;
            n = 0;
            while (!resp_valid_c && n < 20) begin @(negedge clk); n++; end
            check("c_resp_seen", 128'(resp_valid_c), 128'(1));
            check("c_rdata", resp_rdata_c, init_blk(int'(a[9:4])));
            check("c_rd_count", 128'(rd_count_c), 128'((i + 1 > 15) ? 15 : i + 1));
            @(negedge clk);
        end
        check("c_wr_count", 128'(wr_count_c), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
